// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: owns the PC, fetches one word at a time from
// instruction memory and hands {pc[31:2], inst} to the IF/ID register.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [61:0] out_data,
  output logic [1:0]  dbg_state
);

  // Handshakes: a request transfers on a posedge where imem_req_valid &
  // imem_req_ready; a bundle transfers where out_valid & out_ready; neither
  // valid ever depends combinationally on its own ready.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        kill;
  logic        hold_valid;
  logic [31:0] tgt;

  assign tgt            = redirect_pc & 32'hFFFF_FFFC;
  assign imem_req_addr  = pc;
  assign imem_req_valid = (state == S_REQ) && !rst;
  // A redirect squashes the held bundle in the same cycle it arrives.
  assign out_valid      = (state == S_HOLD) && hold_valid && !redirect_valid && !rst;
  assign dbg_state      = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC & 32'hFFFF_FFFC;
      state      <= S_REQ;
      kill       <= 1'b0;
      out_data   <= '0;
      hold_valid <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect_valid) begin
            pc <= tgt;
            if (imem_req_ready) begin
              kill  <= 1'b1;
              state <= S_WAIT;
            end
          end else if (imem_req_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc <= tgt;
            if (imem_resp_valid) begin
              kill  <= 1'b0;
              state <= S_REQ;
            end else begin
              kill <= 1'b1;
            end
          end else if (imem_resp_valid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= S_REQ;
            end else begin
              out_data   <= {pc[31:2], imem_resp_data};
              hold_valid <= 1'b1;
              pc         <= pc + 32'd4;
              state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            hold_valid <= 1'b0;
            pc         <= tgt;
            state      <= S_REQ;
          end else if (hold_valid && out_ready) begin
            hold_valid <= 1'b0;
            state      <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: transaction-level model of program-order fetch plus
// a memory responder, directed scenarios and a randomized run.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_A = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [61:0] out_data;
  logic [1:0]  dbg_state;

  logic        w_rst, w_req_valid, w_req_ready, w_resp_valid;
  logic        w_redirect_valid, w_out_valid, w_out_ready;
  logic [31:0] w_req_addr, w_resp_data, w_redirect_pc;
  logic [61:0] w_out_data;
  logic [1:0]  w_dbg_state;

  ifu_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .dbg_state(dbg_state)
  );

  ifu_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(w_rst),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_req_ready(w_req_ready), .imem_resp_valid(w_resp_valid),
    .imem_resp_data(w_resp_data), .redirect_valid(w_redirect_valid),
    .redirect_pc(w_redirect_pc), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_data(w_out_data), .dbg_state(w_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_xfer = 0;
  int xfer_cyc[$];

  // memory responder
  int          mem_lat = 1;
  bit          data_mode = 1'b0;
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  // program-order model
  logic [31:0] m_pc = RESET_A;
  bit          m_inflight = 1'b0;
  bit          m_stale = 1'b0;
  bit          m_held = 1'b0;
  logic [61:0] m_data = '0;

  logic        s_req_valid, s_out_valid;
  logic [31:0] s_req_addr;
  logic [61:0] s_out_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    mem_word = data_mode ? ((a ^ 32'h5A5A_C3C3) * 32'h0001_0003) : 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs, compare at negedge, advance the model, commit at posedge.
  task automatic step(input logic r, input logic rdy, input logic rv,
                      input logic [31:0] rpc, input logic ordy, input logic fresp);
    logic        resp_now;
    logic        exp_rv, exp_ov;
    logic [31:0] tgt;
    rst = r; imem_req_ready = rdy; redirect_valid = rv;
    redirect_pc = rpc; out_ready = ordy;
    resp_now = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) resp_now = 1'b1;
    end
    imem_resp_valid = resp_now | fresp;
    imem_resp_data  = resp_now ? mem_word(mem_addr) : $urandom;
    @(negedge clk);
    s_req_valid = imem_req_valid; s_req_addr = imem_req_addr;
    s_out_valid = out_valid;      s_out_data = out_data;
    exp_rv = !r && !m_inflight && !m_held;
    exp_ov = !r && m_held && !rv;
    check("req_valid", {63'd0, s_req_valid}, {63'd0, exp_rv});
    if (exp_rv) check("req_addr", {32'd0, s_req_addr}, {32'd0, m_pc});
    check("out_valid", {63'd0, s_out_valid}, {63'd0, exp_ov});
    if (exp_ov) check("out_data", {2'd0, s_out_data}, {2'd0, m_data});
    if (!r) check("state_legal", {63'd0, (dbg_state != 2'd3)}, 64'd1);
    if (s_out_valid && ordy) xfer_cyc.push_back(cyc);
    if (r) mem_busy = 1'b0;
    else begin
      if (resp_now) mem_busy = 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        mem_busy = 1'b1;
        mem_cnt  = (mem_lat == 0) ? $urandom_range(1, 3) : mem_lat;
        mem_addr = imem_req_addr;
      end
    end
    tgt = rpc & 32'hFFFF_FFFC;
    if (r) begin
      m_pc = RESET_A; m_inflight = 0; m_stale = 0; m_held = 0;
    end else if (rv) begin
      m_held = 0;
      if (exp_rv && rdy) begin m_inflight = 1; m_stale = 1; end
      else if (m_inflight && resp_now) m_inflight = 0;
      else if (m_inflight) m_stale = 1;
      m_pc = tgt;
    end else if (exp_rv && rdy) begin
      m_inflight = 1; m_stale = 0;
    end else if (m_inflight && resp_now) begin
      m_inflight = 0;
      if (!m_stale) begin
        m_held = 1;
        m_data = {m_pc[31:2], mem_word(m_pc)};
      end
    end else if (m_held && ordy) begin
      m_held = 0; m_pc = m_pc + 32'd4; n_xfer++;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  initial begin
    int n_before;
    logic [61:0] cap;
    rst = 1; imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0;
    redirect_valid = 0; redirect_pc = '0; out_ready = 0;
    w_rst = 1; w_req_ready = 0; w_resp_valid = 0; w_resp_data = '0;
    w_redirect_valid = 0; w_redirect_pc = '0; w_out_ready = 0;
    @(posedge clk); #1;

    // reset then free-run with 1-cycle memory
    step(1, 1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 0);
    check("rst_req_valid", {63'd0, s_req_valid}, 64'd0);
    xfer_cyc.delete();
    step(0, 1, 0, 0, 1, 0);
    check("t1_first_req", {63'd0, s_req_valid}, 64'd1);
    check("t1_first_addr", {32'd0, s_req_addr}, 64'h8000_0000);
    step(0, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0);
    check("t1_bundle", {2'd0, s_out_data}, {2'd0, 30'h2000_0000, 32'h0000_0013});
    step(0, 1, 0, 0, 1, 0);
    check("t1_next_addr", {32'd0, s_req_addr}, 64'h8000_0004);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 1, 0);
    check("t1_xfer_count", xfer_cyc.size(), 3);
    if (xfer_cyc.size() >= 3) begin
      check("t1_rate_a", xfer_cyc[1] - xfer_cyc[0], 3);
      check("t1_rate_b", xfer_cyc[2] - xfer_cyc[1], 3);
    end

    // backpressure in HOLD
    for (int i = 0; i < 8 && !s_out_valid; i++) step(0, 1, 0, 0, 0, 0);
    check("t2_reach_hold", {63'd0, s_out_valid}, 64'd1);
    cap = s_out_data;
    n_before = n_xfer;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0, 0);
      check("t2_hold_valid", {63'd0, s_out_valid}, 64'd1);
      check("t2_hold_data", {2'd0, s_out_data}, {2'd0, cap});
      check("t2_no_req", {63'd0, s_req_valid}, 64'd0);
    end
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    check("t2_one_xfer", n_xfer - n_before, 1);
    check("t2_back_req", {63'd0, s_req_valid}, 64'd1);

    // redirect while waiting for a slow response
    step(0, 0, 1, 32'h8000_0008, 1, 0);
    mem_lat = 3;
    step(0, 1, 0, 0, 1, 0);
    check("t3_req_addr", {32'd0, s_req_addr}, 64'h8000_0008);
    step(0, 0, 1, 32'h8000_0103, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    check("t3_dropped", {63'd0, s_out_valid}, 64'd0);
    step(0, 0, 0, 0, 1, 0);
    check("t3_new_addr", {32'd0, s_req_addr}, 64'h8000_0100);
    check("t3_no_out", {63'd0, s_out_valid}, 64'd0);

    // redirect in HOLD with out_ready high
    mem_lat = 1;
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    check("t4_in_hold", {63'd0, s_out_valid}, 64'd1);
    n_before = n_xfer;
    step(0, 0, 1, 32'h8000_0200, 1, 0);
    check("t4_masked", {63'd0, s_out_valid}, 64'd0);
    step(0, 0, 0, 0, 1, 0);
    check("t4_tgt_addr", {32'd0, s_req_addr}, 64'h8000_0200);
    check("t4_no_xfer", n_xfer - n_before, 0);

    // reset mid-WAIT, then a late response in REQ
    mem_lat = 3;
    step(0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    check("t6_reset_addr", {32'd0, s_req_addr}, 64'h8000_0000);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0);
    check("t6_no_bundle", {63'd0, s_out_valid}, 64'd0);

    // randomized run
    data_mode = 1'b1;
    mem_lat = 0;
    step(1, 0, 0, 0, 1, 0);
    n_before = n_xfer;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 9) == 0) ? $urandom : (RESET_A + $urandom_range(0, 4095));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) < 8, rp, $urandom_range(0, 9) < 6, 1'b0);
    end
    check("rand_progress", {63'd0, (n_xfer - n_before) > 100}, 64'd1);

    // wrap-around with overridden reset PC
    w_rst = 0; w_req_ready = 1; w_out_ready = 1;
    @(negedge clk);
    check("w_first_req", {63'd0, w_req_valid}, 64'd1);
    check("w_first_addr", {32'd0, w_req_addr}, 64'hFFFF_FFFC);
    @(posedge clk); #1;
    w_resp_valid = 1; w_resp_data = 32'h0000_0013; w_req_ready = 0;
    @(negedge clk);
    check("w_wait_no_req", {63'd0, w_req_valid}, 64'd0);
    @(posedge clk); #1;
    w_resp_valid = 0;
    @(negedge clk);
    check("w_out_valid", {63'd0, w_out_valid}, 64'd1);
    check("w_bundle", {2'd0, w_out_data}, {2'd0, 30'h3FFF_FFFF, 32'h0000_0013});
    check("w_state_legal", {63'd0, (w_dbg_state != 2'd3)}, 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("w_next_req", {63'd0, w_req_valid}, 64'd1);
    check("w_next_addr", {32'd0, w_req_addr}, 64'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction-fetch front end that produces the 62-bit fetch bundle {pc[31:2], inst[31:0]}. This bundle is captured by the IF/ID pipeline register that sits directly downstream. The block owns the PC, runs a valid/ready request plus response-valid handshake to instruction memory, and applies redirects from the execute stage. It presents one bundle at a time with valid/ready; the downstream register's enable is out_valid & out_ready.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  32  fetch address, always equal to pc
imem_req_ready  input  1  memory accepts request this cycle
imem_resp_valid  input  1  instruction data valid
imem_resp_data  input  32  instruction word
redirect_valid  input  1  branch/jump redirect, one-cycle pulse
redirect_pc  input  32  redirect target; bits [1:0] ignored and forced to 0
out_valid  output  1  bundle valid toward the IF/ID register
out_ready  input  1  downstream accepts the bundle
out_data  output  62  {pc_of_inst[31:2], inst[31:0]}

Behaviour:
- Reset (rst=1 at posedge):
  - pc = RESET_PC, state = REQ, kill = 0, out_data = 0, hold_valid = 0.
  - While rst is high: imem_req_valid = 0 and out_valid = 0.
- State REQ:
  - imem_req_valid = 1. It has no combinational dependency on redirect_valid or out_ready.
  - If imem_req_ready = 1, go to WAIT.
- State WAIT:
  - imem_req_valid = 0.
  - On imem_resp_valid with kill = 0: out_data <= {pc[31:2], imem_resp_data}, hold_valid <= 1, pc <= pc + 4, go to HOLD.
  - On imem_resp_valid with kill = 1: discard the data, kill <= 0, go to REQ.
- State HOLD:
  - out_valid = hold_valid & ~redirect_valid (combinational mask).
  - When out_valid & out_ready: hold_valid <= 0, go to REQ.
  - out_data is stable while out_valid = 1 and out_ready = 0.
- Redirect has highest priority; let tgt = {redirect_pc[31:2], 2'b00}:
  - In REQ with imem_req_ready = 0: pc <= tgt, stay in REQ.
  - In REQ with imem_req_ready = 1: the request for the old pc is in flight. pc <= tgt, kill <= 1, go to WAIT.
  - In WAIT without imem_resp_valid: pc <= tgt, kill <= 1.
  - In WAIT with imem_resp_valid in the same cycle: drop the response, pc <= tgt, kill <= 0, go to REQ.
  - In HOLD: the bundle is dropped (masked the same cycle), hold_valid <= 0, pc <= tgt, go to REQ.
- imem_resp_valid is ignored in REQ and HOLD.
- Memory returns exactly one response per accepted request, at the earliest one cycle after acceptance.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Throughput with zero-wait memory and out_ready held at 1: one bundle per 3 cycles (REQ, WAIT, HOLD).
- Latency from request accept to out_valid: response latency + 1 cycle.
- rst asserted in any state returns to the reset values at the next posedge. Any in-flight response is dropped because the block is in REQ and REQ ignores imem_resp_valid; memory is reset by the same rst.

Test Plan:
- Reset then free-run: rst high 2 cycles, then low; memory ready=1 with 1-cycle response of 32'h0000_0013. Required:
  - first imem_req_addr = 32'h8000_0000;
  - out_data = {30'h2000_0000, 32'h0000_0013};
  - next request at 32'h8000_0004;
  - a bundle every 3 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD. Required: out_valid stays 1, out_data unchanged, no new imem_req_valid; on out_ready=1 exactly one transfer, then REQ.
- Redirect while WAITing: pc=32'h8000_0008 in WAIT, redirect_pc=32'h8000_0103, response arrives 2 cycles later. Required: response discarded, no out_valid; next request address 32'h8000_0100.
- Redirect in HOLD with out_ready=1 in the same cycle: required out_valid=0 that cycle, no transfer, next request at the redirect target.
- Wrap-around: RESET_PC overridden to 32'hFFFF_FFFC. Required: first bundle pc field = 30'h3FFF_FFFF; next request address 32'h0000_0000.
- Reset mid-operation: assert rst in WAIT while a response is pending. Required:
  - after release, request at RESET_PC;
  - a late imem_resp_valid while in REQ produces no bundle.
